// File: rtl/uart_tx_fifo_drain_pkg.sv
// Shared types and helpers for the UART transmit drain.
// Contents: serializer state enum, default byte width / burst size,
//           and a baud divisor helper for deriving CLKS_PER_BIT.
package uart_tx_fifo_drain_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   localparam int DEF_W = 8;
   localparam int DEF_N = 4;

   // Rounded clock-to-baud divisor, e.g. 50 MHz / 115200 -> 434.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_drain_if.sv
// Pop-side handshake between the shared byte FIFO and the UART drain.
// Signals: can_pop (entries available, saturated at N), pop (entries taken
//          this cycle), pop_data (head entries, index 0 = oldest).
interface uart_tx_fifo_drain_if
   import uart_tx_fifo_drain_pkg::*;
#(
   parameter int W = DEF_W,
   parameter int N = DEF_N
) ();
   localparam int WN = $clog2(N + 1) + 1;

   logic [WN-1:0]       can_pop;
   logic [WN-1:0]       pop;
   logic [N-1:0][W-1:0] pop_data;

   // master: the drain, which decides how many entries to take
   modport master (input can_pop, input pop_data, output pop);
   // slave: the FIFO, which presents entries and applies pop at posedge
   modport slave  (output can_pop, output pop_data, input pop);
endinterface

// File: rtl/uart_tx_fifo_drain_serializer.sv
// Single-byte UART frame engine: start bit, W data bits LSB first, stop bit(s).
// Ports: clk/rst; load+data start a frame when ready; done pulses on the last
//        stop-bit cycle; tx is the registered serial line (idle high).
module uart_tx_fifo_drain_serializer
   import uart_tx_fifo_drain_pkg::*;
#(
   parameter int W            = DEF_W,
   parameter int CLKS_PER_BIT = 434,
   parameter int STOP_BITS    = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] data,
   output logic         ready,
   output logic         done,
   output logic         tx
);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] BAUD_PRE  = BW'(CLKS_PER_BIT - 2);
   localparam logic [CW-1:0] DATA_LAST = CW'(W - 1);
   localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

   state_t        state;
   logic [BW-1:0] baud;
   logic [CW-1:0] bit_idx;
   logic [W-1:0]  shreg;
   logic          baud_last;

   assign baud_last = (baud == BAUD_LAST);
   // A new byte can be taken while idle, or on the final stop-bit cycle so
   // that consecutive frames run back-to-back with no idle gap.
   assign ready = (state == IDLE) || done;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (load) begin
                  state   <= START;
                  shreg   <= data;
                  tx      <= 1'b0;
                  baud    <= '0;
                  bit_idx <= '0;
               end
            end
            START: begin
               if (baud_last) begin
                  baud  <= '0;
                  state <= DATA;
                  tx    <= shreg[0];
                  shreg <= shreg >> 1;
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud <= '0;
                  if (bit_idx == DATA_LAST) begin
                     state   <= STOP;
                     bit_idx <= '0;
                     tx      <= 1'b1;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     tx      <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end else begin
                  baud <= baud + 1'b1;
               end
            end
            STOP: begin
               if (baud_last) begin
                  baud <= '0;
                  if (bit_idx == STOP_LAST) begin
                     bit_idx <= '0;
                     if (load) begin
                        state <= START;
                        shreg <= data;
                        tx    <= 1'b0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud <= baud + 1'b1;
                  // One cycle of look-ahead keeps done a plain register.
                  done <= (bit_idx == STOP_LAST) && (baud == BAUD_PRE);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART TX drain: pops up to N bytes from the shared FIFO in one cycle, buffers
// them, and sends them as back-to-back frames on tx.
// Ports: clk/rst; fifo (master modport: can_pop/pop_data in, pop out);
//        tx serial line, busy while buffered bytes remain, frame_done per byte.
module uart_tx_fifo_drain
   import uart_tx_fifo_drain_pkg::*;
#(
   parameter int W            = DEF_W,
   parameter int N            = DEF_N,
   parameter int CLKS_PER_BIT = clks_per_bit(50_000_000, 115_200),
   parameter int STOP_BITS    = 1
) (
   input  logic                clk,
   input  logic                rst,
   uart_tx_fifo_drain_if.master fifo,
   output logic                tx,
   output logic                busy,
   output logic                frame_done
);
   localparam int WN   = $clog2(N + 1) + 1;
   localparam int CNTW = $clog2(N + 1);
   localparam int NXT  = (N > 1) ? 1 : 0;

   logic [N-1:0][W-1:0] buffer;   // buffer[0] is the byte currently on the line
   logic [CNTW-1:0]     count;
   logic [WN-1:0]       take;
   logic                ser_ready;
   logic                load;
   logic [W-1:0]        load_data;

   // Pops only when nothing is buffered; can_pop above N is clipped.
   always_comb begin
      take = '0;
      if (!rst && count == '0) begin
         if (fifo.can_pop > WN'(N)) take = WN'(N);
         else                       take = fifo.can_pop;
      end
   end

   assign fifo.pop = take;
   assign busy     = (count != '0);

   // The first byte of a burst goes straight from the FIFO head into the
   // serializer on the pop edge; later bytes come from buffer[1] on the
   // frame_done edge, just before the buffer shifts down.
   assign load      = ser_ready && ((take != '0) || (count > CNTW'(1)));
   assign load_data = (count == '0) ? fifo.pop_data[0] : buffer[NXT];

   always_ff @(posedge clk) begin
      if (rst) begin
         buffer <= '0;
         count  <= '0;
      end else if (take != '0) begin
         buffer <= fifo.pop_data;
         count  <= CNTW'(take);
      end else if (frame_done && count != '0) begin
         for (int i = 0; i < N - 1; i++) buffer[i] <= buffer[i+1];
         buffer[N-1] <= '0;
         count       <= count - 1'b1;
      end
   end

   uart_tx_fifo_drain_serializer #(
      .W            (W),
      .CLKS_PER_BIT (CLKS_PER_BIT),
      .STOP_BITS    (STOP_BITS)
   ) u_ser (
      .clk   (clk),
      .rst   (rst),
      .load  (load),
      .data  (load_data),
      .ready (ser_ready),
      .done  (frame_done),
      .tx    (tx)
   );

endmodule
